// File: rtl/cnn_mac_pipe_snsm.sv
// Pipelined signed multiply-accumulate. Each window is framed by first/last tags, and one sum is emitted per window.
// Define CNN_MAC_SAT_EN to turn on saturating accumulate/output and the ovf flag.
module cnn_mac_pipe_snsm #(
  parameter int DIN0_WIDTH = 10,
  parameter int DIN1_WIDTH = 14,
  parameter int MUL_STAGES = 2,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 25
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         out_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  if (MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_bad_stages
    $error("cnn_mac_pipe_snsm: MUL_STAGES must be in 1..4");
  end
  if (ACC_WIDTH < PW) begin : g_bad_acc
    $error("cnn_mac_pipe_snsm: ACC_WIDTH must hold the full product");
  end
  if (DOUT_WIDTH > ACC_WIDTH) begin : g_bad_dout
    $error("cnn_mac_pipe_snsm: DOUT_WIDTH must not exceed ACC_WIDTH");
  end

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] p_q [MUL_STAGES];
  logic [MUL_STAGES-1:0] v_q, f_q, l_q;

  assign prod = PW'(din0) * PW'(din1);

  always_ff @(posedge clk) begin
    if (ce) begin
      p_q[0] <= prod;
      for (int i = 1; i < MUL_STAGES; i++) p_q[i] <= p_q[i-1];
    end
  end

  // The tags travel with the product, so in-flight beats are dropped when reset clears the valids.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      f_q <= '0;
      l_q <= '0;
    end else if (ce) begin
      v_q[0] <= in_valid;
      f_q[0] <= in_first;
      l_q[0] <= in_last;
      for (int i = 1; i < MUL_STAGES; i++) begin
        v_q[i] <= v_q[i-1];
        f_q[i] <= f_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  logic signed [PW-1:0]         p_tail;
  logic                         v_tail, f_tail, l_tail;
  logic signed [ACC_WIDTH-1:0]  acc, acc_next, base, p_ext;
  logic signed [DOUT_WIDTH-1:0] dout_next;

  assign p_tail = p_q[MUL_STAGES-1];
  assign v_tail = v_q[MUL_STAGES-1];
  assign f_tail = f_q[MUL_STAGES-1];
  assign l_tail = l_q[MUL_STAGES-1];

`ifdef CNN_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] DOUT_MAX =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] DOUT_MIN =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] sum_w;
  logic               acc_clamp, dout_clamp, sticky, sticky_next;

  // One extra sum bit exposes signed overflow; on overflow its top bit gives the true sign.
  always_comb begin
    p_ext       = ACC_WIDTH'(p_tail);
    base        = f_tail ? '0 : acc;
    sum_w       = {base[ACC_WIDTH-1], base} + {p_ext[ACC_WIDTH-1], p_ext};
    acc_clamp   = sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1];
    acc_next    = sum_w[ACC_WIDTH-1:0];
    if (acc_clamp) acc_next = sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    dout_clamp  = (acc_next > DOUT_MAX) || (acc_next < DOUT_MIN);
    dout_next   = acc_next[DOUT_WIDTH-1:0];
    if (dout_clamp)
      dout_next = acc_next[ACC_WIDTH-1] ? DOUT_MIN[DOUT_WIDTH-1:0] : DOUT_MAX[DOUT_WIDTH-1:0];
    sticky_next = (f_tail ? 1'b0 : sticky) | acc_clamp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      sticky    <= 1'b0;
    end else if (ce) begin
      out_valid <= v_tail & l_tail;
      if (v_tail) begin
        acc    <= l_tail ? '0 : acc_next;
        sticky <= l_tail ? 1'b0 : sticky_next;
        if (l_tail) begin
          dout <= dout_next;
          ovf  <= sticky_next | dout_clamp;
        end
      end
    end
  end
`else
  always_comb begin
    p_ext     = ACC_WIDTH'(p_tail);
    base      = f_tail ? '0 : acc;
    acc_next  = base + p_ext;
    dout_next = acc_next[DOUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else if (ce) begin
      out_valid <= v_tail & l_tail;
      if (v_tail) begin
        acc <= l_tail ? '0 : acc_next;
        if (l_tail) dout <= dout_next;
      end
    end
  end

  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_mac_pipe_snsm.sv
// Self-checking bench for cnn_mac_pipe_snsm: directed scenarios plus random traffic against a window-sum model.
// Expectations follow CNN_MAC_SAT_EN in the same way as the design.
module tb_cnn_mac_pipe_snsm;
  localparam int MS = 2;
  localparam int D0 = 10;
  localparam int D1 = 14;
  localparam int AW = 32;
  localparam int DW = 25;
  localparam longint ACC_MAX  = (longint'(1) << (AW-1)) - 1;
  localparam longint ACC_MIN  = -(longint'(1) << (AW-1));
  localparam longint DOUT_MAX = (longint'(1) << (DW-1)) - 1;
  localparam longint DOUT_MIN = -(longint'(1) << (DW-1));

  logic clk = 1'b0;
  logic reset, ce, in_valid, in_first, in_last;
  logic signed [D0-1:0] din0;
  logic signed [D1-1:0] din1;
  logic out_valid, ovf;
  logic signed [DW-1:0] dout;

  cnn_mac_pipe_snsm #(
    .DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .MUL_STAGES(MS), .ACC_WIDTH(AW), .DOUT_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1), .out_valid(out_valid), .dout(dout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [DW-1:0] d;
    logic        o;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int ecount = 0;
  longint sum = 0;
  bit sticky = 1'b0;
  logic exp_ov = 1'b0;
  logic [DW-1:0] exp_dout = '0;
  logic exp_ovf = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
    end
  endtask

  // Drive one cycle, advance the window model by one clock edge, then check the outputs.
  task automatic applyStimulus(input bit rst, input bit ce_i, input bit v, input bit f,
                               input bit l, input int a, input int b);
    longint p, res;
    bit o;
    exp_t e;
    @(negedge clk);
    reset = rst; ce = ce_i; in_valid = v; in_first = f; in_last = l;
    din0 = D0'(a); din1 = D1'(b);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      sum = 0; sticky = 1'b0;
      exp_ov = 1'b0; exp_dout = '0; exp_ovf = 1'b0;
    end else if (ce_i) begin
      ecount++;
      exp_ov = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == ecount) begin
        exp_ov = 1'b1;
        exp_dout = exp_q[0].d;
        exp_ovf = exp_q[0].o;
        void'(exp_q.pop_front());
      end
      if (v) begin
        p = longint'(a) * longint'(b);
        if (f) begin
          sum = p;
          sticky = 1'b0;
        end else begin
          sum = sum + p;
`ifdef CNN_MAC_SAT_EN
          if (sum > ACC_MAX) begin sum = ACC_MAX; sticky = 1'b1; end
          if (sum < ACC_MIN) begin sum = ACC_MIN; sticky = 1'b1; end
`endif
        end
        if (l) begin
          res = sum;
          o = sticky;
`ifdef CNN_MAC_SAT_EN
          if (res > DOUT_MAX) begin res = DOUT_MAX; o = 1'b1; end
          if (res < DOUT_MIN) begin res = DOUT_MIN; o = 1'b1; end
`endif
          e.due = ecount + MS;
          e.d = DW'(res);
          e.o = o;
          exp_q.push_back(e);
          sum = 0;
          sticky = 1'b0;
        end
      end
    end
    #1;
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    checkOutput("dout", {7'd0, dout}, {7'd0, exp_dout});
    checkOutput("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    din0 = '0; din1 = '0;
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    // single-product window
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, -3, 100);
    idle(4);
    checkOutput("t1_const", 32'(dout), 32'(-300));

    // four-beat window followed immediately by a one-beat window
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, i == 1, i == 4, i, 10);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5, -2);
    idle(4);
    checkOutput("t2_const", 32'(dout), 32'(-10));

    // stall mid-window, then stall while the result pulse is up
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7, -9);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -11, 13);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 100, 100);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 20, 30);
    idle(2);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(3);

    // reset with beats in flight; the next window has no first tag
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 50, 60);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 70, 80);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 3);
    idle(4);
    checkOutput("t4_const", 32'(dout), 32'(6));

    // long window that overflows the accumulator
    for (int i = 0; i < 600; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, i == 0, i == 599, -512, -8192);
    idle(4);

    // random traffic: gaps, stalls, stray first/last tags and occasional resets
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 85,
                    $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 20,
                    int'($urandom_range(0, 1023)) - 512,
                    int'($urandom_range(0, 16383)) - 8192);
    end
    idle(MS + 3);
    checkOutput("drain", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
